// File: rtl/axi4_lite_arb_pkg.sv
// Shared types and round-robin helper for the block-burst arbiter.
package axi4_lite_arb_pkg;

  typedef enum logic [1:0] {
    e_idle  = 2'd0,
    e_issue = 2'd1,
    e_burst = 2'd2
  } state_e;

  localparam int max_req_lp = 32;

  // First asserted index searching last+1, last+2, ... modulo n; returns last if none.
  function automatic int rr_pick(input logic [max_req_lp-1:0] req, input int n, input int last);
    int idx;
    rr_pick = last;
    for (int k = max_req_lp; k >= 1; k--) begin
      if (k <= n) begin
        idx = (last + k) % n;
        if (req[idx[4:0]]) rr_pick = idx;
      end
    end
  endfunction

endpackage

// File: rtl/axi4_lite_arb_tag_fifo.sv
// In-order FIFO of granted requester IDs, consumed by the response path.
module axi4_lite_arb_tag_fifo #(
  parameter int width_p = 2,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_n_i,
  input  logic [width_p-1:0] data_i,
  input  logic               push_i,
  input  logic               pop_i,
  output logic [width_p-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p) + 1;

  logic [width_p-1:0]  mem_r [els_p];
  logic [ptr_w_lp-1:0] wr_ptr_r, rd_ptr_r;
  logic [cnt_w_lp-1:0] count_r;
  logic                push_en, pop_en;

  assign full_o  = (count_r == cnt_w_lp'(els_p));
  assign empty_o = (count_r == '0);
  assign push_en = push_i & ~full_o;
  assign pop_en  = pop_i & ~empty_o;
  assign data_o  = empty_o ? '0 : mem_r[rd_ptr_r];

  always_ff @(posedge clk_i) begin
    if (push_en) mem_r[wr_ptr_r] <= data_i;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_en) wr_ptr_r <= wr_ptr_r + 1'b1;
      if (pop_en)  rd_ptr_r <= rd_ptr_r + 1'b1;
      case ({push_en, pop_en})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/axi4_lite_block_arbiter.sv
// Round-robin arbiter granting one requester per block on a shared burst sequencer.
//   state   | meaning
//   e_idle  | no grant; pick next requester if any valid and tag FIFO not full
//   e_issue | grant held, first-beat address presented to sequencer
//   e_burst | first beat accepted, waiting for sequencer done
module axi4_lite_block_arbiter
  import axi4_lite_arb_pkg::*;
#(
  parameter int num_req_p         = 4,
  parameter int axi_addr_width_p  = 28,
  parameter int words_per_block_p = 8,
  parameter int max_outstanding_p = 4,
  localparam int id_width_lp      = $clog2(num_req_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_n_i,
  input  logic [num_req_p*axi_addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p-1:0]                  req_v_i,
  output logic [num_req_p-1:0]                  req_ready_and_o,
  output logic [axi_addr_width_p-1:0]           addr_o,
  output logic                                  v_o,
  input  logic                                  ready_and_i,
  input  logic                                  done_i,
  output logic [id_width_lp-1:0]                owner_id_o,
  output logic                                  busy_o,
  output logic [id_width_lp-1:0]                resp_id_o,
  output logic                                  resp_v_o,
  input  logic                                  resp_yumi_i
);

  state_e                  state_r;
  logic [id_width_lp-1:0]  owner_r, rr_last_r, winner;
  logic [max_req_lp-1:0]   req_ext;
  logic                    fifo_full, fifo_empty, push, pop;

  assign req_ext = max_req_lp'(req_v_i);
  assign winner  = id_width_lp'(rr_pick(req_ext, num_req_p, int'(rr_last_r)));

  always_comb begin
    v_o             = 1'b0;
    addr_o          = '0;
    req_ready_and_o = '0;
    if (state_r == e_issue) begin
      addr_o                   = req_addr_i[int'(owner_r)*axi_addr_width_p +: axi_addr_width_p];
      v_o                      = req_v_i[owner_r];
      req_ready_and_o[owner_r] = ready_and_i;
    end
  end

  assign push = (state_r == e_issue) & v_o & ready_and_i;
  assign pop  = resp_yumi_i & ~fifo_empty;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r    <= e_idle;
      owner_r    <= '0;
      rr_last_r  <= id_width_lp'(num_req_p - 1);
      busy_o     <= 1'b0;
      owner_id_o <= '0;
    end else begin
      case (state_r)
        e_idle: begin
          if ((|req_v_i) && !fifo_full) begin
            owner_r    <= winner;
            rr_last_r  <= winner;
            owner_id_o <= winner;
            busy_o     <= 1'b1;
            state_r    <= e_issue;
          end
        end
        e_issue: begin
          if (push) begin
            if (words_per_block_p == 1) begin
              state_r    <= e_idle;
              busy_o     <= 1'b0;
              owner_id_o <= '0;
            end else begin
              state_r <= e_burst;
            end
          end
        end
        e_burst: begin
          if (done_i) begin
            state_r    <= e_idle;
            busy_o     <= 1'b0;
            owner_id_o <= '0;
          end
        end
        default: begin
          state_r    <= e_idle;
          busy_o     <= 1'b0;
          owner_id_o <= '0;
        end
      endcase
    end
  end

  axi4_lite_arb_tag_fifo #(
    .width_p (id_width_lp),
    .els_p   (max_outstanding_p)
  ) tag_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .data_i    (owner_r),
    .push_i    (push),
    .pop_i     (pop),
    .data_o    (resp_id_o),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  assign resp_v_o = ~fifo_empty;

`ifndef SYNTHESIS
  // Protocol misuse by the requesters or the sequencer.
  always @(posedge clk_i) begin
    if (reset_n_i) begin
      if (words_per_block_p > 1) assert (!(done_i && (state_r != e_burst)));
      assert (!(resp_yumi_i && fifo_empty));
      if (state_r == e_issue) assert (req_v_i[owner_r]);
    end
  end
`endif

endmodule

// File: tb/tb_axi4_lite_block_arbiter.sv
// Directed scoreboard bench: a burst-mode instance (8 beats) and a passthrough instance (1 beat).
module tb_axi4_lite_block_arbiter;

  localparam int n_lp = 4;
  localparam int aw_lp = 28;

  logic clk_i = 1'b0;
  logic reset_n_i = 1'b0;
  always #5 clk_i = ~clk_i;

  logic [n_lp*aw_lp-1:0] a_req_addr, b_req_addr;
  logic [n_lp-1:0] a_req_v, a_req_ready, b_req_v, b_req_ready;
  logic [aw_lp-1:0] a_addr, b_addr;
  logic a_v, a_ready, a_done, a_busy, a_resp_v, a_yumi;
  logic b_v, b_ready, b_done, b_busy, b_resp_v, b_yumi;
  logic [1:0] a_owner, a_resp_id, b_owner, b_resp_id;

  axi4_lite_block_arbiter #(.words_per_block_p(8)) dut_a (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_addr_i(a_req_addr), .req_v_i(a_req_v),
    .req_ready_and_o(a_req_ready), .addr_o(a_addr), .v_o(a_v), .ready_and_i(a_ready),
    .done_i(a_done), .owner_id_o(a_owner), .busy_o(a_busy), .resp_id_o(a_resp_id),
    .resp_v_o(a_resp_v), .resp_yumi_i(a_yumi));

  axi4_lite_block_arbiter #(.words_per_block_p(1)) dut_b (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .req_addr_i(b_req_addr), .req_v_i(b_req_v),
    .req_ready_and_o(b_req_ready), .addr_o(b_addr), .v_o(b_v), .ready_and_i(b_ready),
    .done_i(b_done), .owner_id_o(b_owner), .busy_o(b_busy), .resp_id_o(b_resp_id),
    .resp_v_o(b_resp_v), .resp_yumi_i(b_yumi));

  int vec = 0;
  int errs = 0;
  int exp_q[$], resp_q[$], bexp_q[$], bresp_q[$];

  function automatic logic [aw_lp-1:0] addr_of(input int i);
    case (i)
      0: addr_of = 28'h0000100;
      1: addr_of = 28'h0000200;
      2: addr_of = 28'h0000040;
      default: addr_of = 28'h0ABCDE0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    a_req_v = '0; a_ready = 0; a_done = 0; a_yumi = 0;
    b_req_v = '0; b_ready = 0; b_yumi = 0;
    reset_n_i = 0;
    cyc();
    chk("rst_v", a_v, 0);
    chk("rst_addr", a_addr, 0);
    chk("rst_ready", a_req_ready, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_owner", a_owner, 0);
    chk("rst_resp_v", a_resp_v, 0);
    chk("rst_resp_id", a_resp_id, 0);
    reset_n_i = 1;
    exp_q.delete(); resp_q.delete(); bexp_q.delete(); bresp_q.delete();
  endtask

  // Wait for v_o on the burst instance; a grant is expected one cycle after the decision cycle.
  task automatic a_wait();
    int lat;
    lat = 0;
    for (int i = 1; i <= 16; i++) begin
      cyc();
      a_yumi = 0;
      if (a_v) begin
        lat = i;
        break;
      end
    end
    chk("grant_latency", lat, 1);
  endtask

  // From e_issue through done to the following e_idle cycle; optionally pop the oldest tag.
  task automatic a_block(input bit pop);
    int e;
    logic [3:0] oh;
    e = exp_q.pop_front();
    oh = 4'b0001 << e;
    chk("owner", a_owner, e);
    chk("addr", a_addr, addr_of(e));
    chk("busy_issue", a_busy, 1);
    a_ready = 1;
    #1 chk("req_ready", a_req_ready, oh);
    cyc();
    a_ready = 0;
    resp_q.push_back(e);
    chk("v_burst", a_v, 0);
    chk("resp_v_after_push", a_resp_v, 1);
    repeat (6) cyc();
    a_done = 1;
    cyc();
    a_done = 0;
    chk("busy_idle", a_busy, 0);
    chk("bubble_v", a_v, 0);
    if (pop) begin
      chk("resp_id", a_resp_id, resp_q.pop_front());
      a_yumi = 1;
    end
  endtask

  initial begin
    int e, prev;
    for (int i = 0; i < n_lp; i++) begin
      a_req_addr[i*aw_lp +: aw_lp] = addr_of(i);
      b_req_addr[i*aw_lp +: aw_lp] = addr_of(i);
    end
    b_done = 0;

    // Single requester 2
    do_reset();
    a_req_v = 4'b0100;
    exp_q.push_back(2);
    a_wait();
    a_block(1);
    a_req_v = '0;
    cyc();
    a_yumi = 0;
    chk("single_drain", a_resp_v, 0);

    // All four held valid, popped every block
    do_reset();
    a_req_v = 4'b1111;
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
    exp_q.push_back(3); exp_q.push_back(0);
    for (int k = 0; k < 5; k++) begin
      a_wait();
      a_block(1);
    end
    a_req_v = '0;
    cyc();
    a_yumi = 0;
    chk("rr_drain", a_resp_v, 0);

    // Tag FIFO fill blocks further grants
    do_reset();
    a_req_v = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(0);
      a_wait();
      a_block(0);
    end
    a_req_v = 4'b0010;
    repeat (3) cyc();
    chk("full_no_grant_v", a_v, 0);
    chk("full_no_grant_busy", a_busy, 0);
    chk("full_resp_id", a_resp_id, resp_q.pop_front());
    a_yumi = 1;
    cyc();
    a_yumi = 0;
    chk("full_decision_v", a_v, 0);
    cyc();
    chk("full_release_v", a_v, 1);
    exp_q.push_back(1);
    a_block(1);
    a_req_v = '0;
    cyc();
    a_yumi = 0;
    while (resp_q.size() > 0) begin
      chk("fill_drain_v", a_resp_v, 1);
      chk("fill_drain_id", a_resp_id, resp_q.pop_front());
      a_yumi = 1;
      cyc();
      a_yumi = 0;
    end
    chk("fill_empty", a_resp_v, 0);

    // Push and pop in the same cycle with one tag held
    do_reset();
    a_req_v = 4'b0001;
    exp_q.push_back(0);
    a_wait();
    a_block(0);
    a_req_v = 4'b1000;
    exp_q.push_back(3);
    a_wait();
    e = exp_q.pop_front();
    chk("pp_owner", a_owner, e);
    chk("pp_old_id", a_resp_id, resp_q.pop_front());
    a_ready = 1;
    a_yumi = 1;
    cyc();
    a_ready = 0;
    a_yumi = 0;
    chk("pp_resp_v", a_resp_v, 1);
    chk("pp_new_id", a_resp_id, e);
    a_req_v = '0;
    repeat (6) cyc();
    a_done = 1;
    cyc();
    a_done = 0;
    a_yumi = 1;
    cyc();
    a_yumi = 0;
    chk("pp_count_one", a_resp_v, 0);

    // Passthrough instance: grant every two cycles
    do_reset();
    b_ready = 1;
    b_req_v = 4'b1111;
    bexp_q.push_back(0); bexp_q.push_back(1); bexp_q.push_back(2);
    bexp_q.push_back(3); bexp_q.push_back(0);
    prev = 0;
    for (int i = 1; i <= 20 && bexp_q.size() > 0; i++) begin
      cyc();
      b_yumi = 0;
      if (b_resp_v) begin
        chk("b_resp_id", b_resp_id, bresp_q.pop_front());
        b_yumi = 1;
      end
      if (b_v) begin
        e = bexp_q.pop_front();
        chk("b_owner", b_owner, e);
        if (prev != 0) chk("b_gap", i - prev, 2);
        prev = i;
        bresp_q.push_back(e);
      end
    end
    chk("b_all_granted", bexp_q.size(), 0);
    cyc();
    b_req_v = '0;
    b_ready = 0;
    for (int i = 0; i < 6; i++) begin
      b_yumi = 0;
      if (b_resp_v) begin
        chk("b_drain_id", b_resp_id, bresp_q.pop_front());
        b_yumi = 1;
      end
      cyc();
    end
    b_yumi = 0;
    chk("b_drain_all", bresp_q.size(), 0);
    chk("b_drain_empty", b_resp_v, 0);

    // Reset during e_burst with two tags held
    do_reset();
    a_req_v = 4'b0011;
    exp_q.push_back(0); exp_q.push_back(1);
    a_wait();
    a_block(0);
    a_wait();
    e = exp_q.pop_front();
    chk("mid_owner", a_owner, e);
    a_ready = 1;
    cyc();
    a_ready = 0;
    cyc();
    chk("mid_two_tags", a_resp_v, 1);
    #2 reset_n_i = 0;
    #1;
    chk("mid_rst_v", a_v, 0);
    chk("mid_rst_resp_v", a_resp_v, 0);
    chk("mid_rst_busy", a_busy, 0);
    resp_q.delete();
    a_req_v = 4'b1111;
    cyc();
    reset_n_i = 1;
    exp_q.push_back(0);
    a_wait();
    a_block(1);
    a_req_v = '0;
    cyc();
    a_yumi = 0;
    chk("post_rst_empty", a_resp_v, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
